// File: rtl/onchip_memory_pkg.sv
// Shared constants and helpers for the pipelined on-chip memory slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onchip_memory_pkg;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    // Number of byte lanes for a given data width.
    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_memory_array.sv
// Byte-enabled single-port RAM with registered read, shaped for block-RAM inference.
// Latency: read data appears one edge after rd_en.
// Backpressure: none; the caller gates wr_en/rd_en with its clock enable.
module onchip_memory_array
    import onchip_memory_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter     INIT_FILE = ""
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [be_w(DATA_W)-1:0] be,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata
);

    localparam int BE_W = be_w(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Avalon-MM on-chip memory slave; ONCHIP_MEM_RANGE_CHECK_EN adds out-of-range detection.
// Latency: readdatavalid READ_LATENCY (1 or 2) enabled edges after an accepted read.
// Backpressure: waitrequest = ~clken; clken low freezes the whole read pipeline.
module onchip_memory_pipelined
    import onchip_memory_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 12,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "system_onchip_memory.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chipselect,
    input  logic [ADDR_W-1:0]       address,
    input  logic [be_w(DATA_W)-1:0] byteenable,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_W-1:0]       writedata,
    input  logic                    clken,
    output logic                    waitrequest,
    output logic [DATA_W-1:0]       readdata,
    output logic                    readdatavalid,
    output logic                    addr_err
);

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] dat;
    } rd_stage_t;

    if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_latency
        $fatal(1, "onchip_memory_pipelined: READ_LATENCY must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_width
        $fatal(1, "onchip_memory_pipelined: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $fatal(1, "onchip_memory_pipelined: DEPTH must be in 1..2**ADDR_W");
    end

    logic              access;
    logic              rd_acc;
    logic              wr_acc;
    logic              in_range;
    logic [DATA_W-1:0] ram_rdata;
    logic              s0_vld;
    logic              s0_live;
    logic [DATA_W-1:0] s0_dat;

    assign access      = chipselect & (read | write) & clken;
    assign wr_acc      = access & write;
    // A simultaneous read and write is treated as a write only.
    assign rd_acc      = access & read & ~write;
    assign waitrequest = ~clken;

`ifdef ONCHIP_MEM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic err_q;

    assign in_range = ({1'b0, address} < DEPTH_L);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (access && !in_range) begin
            err_q <= 1'b1;
        end
    end

    assign addr_err = err_q;
`else
    assign in_range = 1'b1;
    assign addr_err = 1'b0;
`endif

    onchip_memory_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .wr_en (wr_acc & in_range),
        .rd_en (rd_acc),
        .addr  (address),
        .be    (byteenable),
        .wdata (writedata),
        .rdata (ram_rdata)
    );

    // The RAM output register is the first pipeline stage. It has no reset, so
    // s0_live masks it to zero after reset and for out-of-range reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_vld  <= 1'b0;
            s0_live <= 1'b0;
        end else if (clken) begin
            s0_vld <= rd_acc;
            if (rd_acc) s0_live <= in_range;
        end
    end

    assign s0_dat = s0_live ? ram_rdata : '0;

    if (READ_LATENCY == 1) begin : g_lat1
        assign readdata      = s0_dat;
        assign readdatavalid = s0_vld;
    end else begin : g_lat2
        rd_stage_t s1;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1 <= '0;
            end else if (clken) begin
                s1.vld <= s0_vld;
                if (s0_vld) s1.dat <= s0_dat;
            end
        end

        assign readdata      = s1.dat;
        assign readdatavalid = s1.vld;
    end

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Directed bench: latency-1 (DEPTH 4096) and latency-2 (DEPTH 3000) instances share one stimulus.
module tb_onchip_memory_pipelined;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic [11:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        clken;

    logic        wr1, rdv1, err1;
    logic        wr2, rdv2, err2;
    logic [31:0] rd1, rd2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onchip_memory_pipelined #(
        .DATA_W(32), .ADDR_W(12), .DEPTH(4096), .READ_LATENCY(1), .INIT_FILE("")
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .waitrequest(wr1), .readdata(rd1), .readdatavalid(rdv1),
        .addr_err(err1)
    );

    onchip_memory_pipelined #(
        .DATA_W(32), .ADDR_W(12), .DEPTH(3000), .READ_LATENCY(2), .INIT_FILE("")
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .waitrequest(wr2), .readdata(rd2), .readdatavalid(rdv2),
        .addr_err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] dval(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    // Expected word index on each output after each stall-test edge (-1: no valid).
    int e1 [13] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7, -1, -1};
    int e2 [13] = '{-1, 0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7, -1};

    initial begin
        int b1;
        int b2;
        int a;
        b1 = 0;
        b2 = 0;
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        clken = 1'b1; address = '0; byteenable = '0; writedata = '0;
        step(); step();
        chk("rst_rdv1", rdv1, 1'b0);
        chk("rst_rd1",  rd1,  32'h0);
        chk("rst_rdv2", rdv2, 1'b0);
        chk("rst_rd2",  rd2,  32'h0);
        chk("rst_err1", err1, 1'b0);
        chk("rst_err2", err2, 1'b0);
        chk("rst_wreq", wr1,  1'b0);
        reset_n = 1'b1;
        step();

        // Full-word write, then read the next cycle
        chipselect = 1'b1; write = 1'b1; address = 12'd5; byteenable = 4'hF;
        writedata = 32'hDEADBEEF;
        step();
        write = 1'b0; read = 1'b1;
        step();
        chipselect = 1'b0; read = 1'b0;
        chk("t1_rdv1", rdv1, 1'b1);
        chk("t1_rd1",  rd1,  32'hDEADBEEF);
        chk("t1_rdv2_early", rdv2, 1'b0);
        step();
        chk("t1_rdv1_pulse", rdv1, 1'b0);
        chk("t1_rd1_hold", rd1, 32'hDEADBEEF);
        chk("t1_rdv2", rdv2, 1'b1);
        chk("t1_rd2",  rd2,  32'hDEADBEEF);
        step();
        chk("t1_rdv2_pulse", rdv2, 1'b0);

        // Partial byte-enable write
        chipselect = 1'b1; write = 1'b1; address = 12'd7; byteenable = 4'hF;
        writedata = 32'hAAAAAAAA;
        step();
        byteenable = 4'h5; writedata = 32'h11223344;
        step();
        write = 1'b0; read = 1'b1;
        step();
        chipselect = 1'b0; read = 1'b0;
        chk("t2_rdv1", rdv1, 1'b1);
        chk("t2_rd1",  rd1,  32'hAA22AA44);
        step();
        chk("t2_rdv2", rdv2, 1'b1);
        chk("t2_rd2",  rd2,  32'hAA22AA44);
        step();

        // Back-to-back reads with a 3-cycle clken stall
        chipselect = 1'b1; write = 1'b1; byteenable = 4'hF;
        for (int i = 0; i < 8; i++) begin
            address = 12'(i); writedata = dval(i);
            step();
        end
        write = 1'b0;
        for (int c = 0; c < 13; c++) begin
            clken = !(c >= 4 && c <= 6);
            read  = (c <= 10);
            a = (c < 4) ? c : (c < 7) ? 4 : c - 3;
            address = 12'(a);
            step();
            chk($sformatf("t3_wreq_c%0d", c), wr1, (c >= 4 && c <= 6) ? 1'b1 : 1'b0);
            chk($sformatf("t3_rdv1_c%0d", c), rdv1, (e1[c] >= 0) ? 1'b1 : 1'b0);
            chk($sformatf("t3_rdv2_c%0d", c), rdv2, (e2[c] >= 0) ? 1'b1 : 1'b0);
            if (e1[c] >= 0) chk($sformatf("t3_rd1_c%0d", c), rd1, dval(e1[c]));
            if (e2[c] >= 0) chk($sformatf("t3_rd2_c%0d", c), rd2, dval(e2[c]));
            if (rdv1 && clken) b1++;
            if (rdv2 && clken) b2++;
        end
        chk("t3_beats1", 32'(b1), 32'd8);
        chk("t3_beats2", 32'(b2), 32'd8);
        chipselect = 1'b0; read = 1'b0; clken = 1'b1;
        step();

        // Read and write together: write wins, read dropped
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 12'd9;
        byteenable = 4'hF; writedata = 32'h5A5A5A5A;
        step();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        chk("t4_no_rdv1", rdv1, 1'b0);
        step();
        chk("t4_no_rdv1b", rdv1, 1'b0);
        chk("t4_no_rdv2",  rdv2, 1'b0);
        chipselect = 1'b1; read = 1'b1; address = 12'd9;
        step();
        chipselect = 1'b0; read = 1'b0;
        chk("t4_rdv1", rdv1, 1'b1);
        chk("t4_rd1",  rd1,  32'h5A5A5A5A);
        step();
        chk("t4_rdv2", rdv2, 1'b1);
        chk("t4_rd2",  rd2,  32'h5A5A5A5A);
        step();

        // Reset with two reads in flight
        chipselect = 1'b1; read = 1'b1; address = 12'd0;
        step();
        address = 12'd1;
        step();
        chipselect = 1'b0; read = 1'b0;
        chk("t5_pre_rdv2", rdv2, 1'b1);
        chk("t5_pre_rd1",  rd1,  dval(1));
        reset_n = 1'b0;
        #1;
        chk("t5_rst_rdv1", rdv1, 1'b0);
        chk("t5_rst_rd1",  rd1,  32'h0);
        chk("t5_rst_rdv2", rdv2, 1'b0);
        chk("t5_rst_rd2",  rd2,  32'h0);
        step(); step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t5_stale_rdv1_%0d", k), rdv1, 1'b0);
            chk($sformatf("t5_stale_rdv2_%0d", k), rdv2, 1'b0);
        end

`ifdef ONCHIP_MEM_RANGE_CHECK_EN
        // Out-of-range access on the DEPTH=3000 instance
        chipselect = 1'b1; read = 1'b1; address = 12'd9;
        step();
        read = 1'b0; write = 1'b1; address = 12'd3500; writedata = 32'hFFFFFFFF;
        step();
        chipselect = 1'b0; write = 1'b0;
        chk("t6_rdv2_in",  rdv2, 1'b1);
        chk("t6_rd2_in",   rd2,  32'h5A5A5A5A);
        chk("t6_err2_set", err2, 1'b1);
        chk("t6_err1_low", err1, 1'b0);
        chipselect = 1'b1; read = 1'b1; address = 12'd3500;
        step();
        chipselect = 1'b0; read = 1'b0;
        step();
        chk("t6_rdv2_oor", rdv2, 1'b1);
        chk("t6_rd2_oor",  rd2,  32'h0);
        chk("t6_rd1_wrap", rd1,  32'hFFFFFFFF);
        step(); step();
        chk("t6_err2_sticky", err2, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t6_err2_rst", err2, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        chk("t6_err2_after", err2, 1'b0);
`else
        chk("t6_err1_tied", err1, 1'b0);
        chk("t6_err2_tied", err2, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
